// File: rtl/fire8_squeeze_ofm_writer.sv
`default_nettype none
// ============================================================================
// Module   : fire8_squeeze_ofm_writer
// Purpose  : Captures one pixel vector of DSP_NO channel results from the
//            fire8 squeeze layer and drains it, one channel per cycle, into a
//            channel-major feature-map RAM. Raises ram_feedback once all
//            WOUT*WOUT pixels of the layer have been written.
// Revision : 1.0  initial release
// ============================================================================
module fire8_squeeze_ofm_writer #(
  parameter  int WIDTH  = 16,
  parameter  int DSP_NO = 112,
  parameter  int WOUT   = 8,
  localparam int PIX    = WOUT * WOUT,
  localparam int ADDR_W = $clog2(DSP_NO * PIX)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample,
  input  logic [WIDTH-1:0]  ofm [DSP_NO],
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WIDTH-1:0]  ram_din,
  output logic              ram_feedback,
  output logic              busy,
  output logic              overrun_err
);

  // Channel counter needs at least one bit even for a single-channel build.
  localparam int CH_W  = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;
  // One extra bit so pix can sit at its terminal value PIX after the map.
  localparam int PIX_W = $clog2(PIX) + 1;

  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(DSP_NO - 1);
  localparam logic [CH_W-1:0]  CH_ZERO  = '0;
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  logic [CH_W-1:0]   ch;      // channel whose word is on ram_din this cycle
  logic [PIX_W-1:0]  pix;     // pixel currently being drained
  logic [WIDTH-1:0]  shadow [DSP_NO];

  logic [CH_W-1:0]   ch_inc;
  logic [PIX_W-1:0]  pix_inc;
  logic              last_ch;
  logic              last_pix;
  logic              capture;

  assign ch_inc   = ch + CH_W'(1);
  assign pix_inc  = pix + PIX_W'(1);
  assign last_ch  = (ch == CH_LAST);
  assign last_pix = (pix == PIX_LAST);

  // A new vector is taken when idle, or in the final drain cycle of a pixel
  // that does not finish the map (seamless back-to-back pixels).
  assign capture = sample &&
                   ((state == IDLE) ||
                    ((state == DRAIN) && last_ch && !last_pix));

  // Channel-major address: channel c, pixel p lives at c*PIX + p.
  function automatic logic [ADDR_W-1:0] addr_of(input logic [CH_W-1:0]  c,
                                                 input logic [PIX_W-1:0] p);
    return ADDR_W'(c) * ADDR_W'(PIX) + ADDR_W'(p);
  endfunction

  // Shadow buffer holds the captured vector; deliberately not reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      shadow <= ofm;
    end
  end

  // Control FSM and registered RAM-side outputs. The first word of a captured
  // vector is taken straight from ofm so the write lands in the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ch           <= '0;
      pix          <= '0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_din      <= '0;
      ram_feedback <= 1'b0;
      busy         <= 1'b0;
      overrun_err  <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      case (state)
        IDLE: begin
          if (sample) begin
            state    <= DRAIN;
            busy     <= 1'b1;
            ch       <= '0;
            ram_we   <= 1'b1;
            ram_addr <= addr_of(CH_ZERO, pix);
            ram_din  <= ofm[0];
          end
        end

        DRAIN: begin
          if (!last_ch) begin
            // Mid-pixel: a new sample cannot be held, so it is dropped.
            if (sample) begin
              overrun_err <= 1'b1;
            end
            ch       <= ch_inc;
            ram_we   <= 1'b1;
            ram_addr <= addr_of(ch_inc, pix);
            ram_din  <= shadow[ch_inc];
          end else begin
            ch  <= '0;
            pix <= pix_inc;
            if (last_pix) begin
              state        <= DONE;
              busy         <= 1'b0;
              ram_feedback <= 1'b1;
              if (sample) begin
                overrun_err <= 1'b1;
              end
            end else if (sample) begin
              ram_we   <= 1'b1;
              ram_addr <= addr_of(CH_ZERO, pix_inc);
              ram_din  <= ofm[0];
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        DONE: begin
          ram_feedback <= 1'b1;
          if (sample) begin
            overrun_err <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/fire8_squeeze_ofm_writer.md
FIRE8_SQUEEZE_OFM_WRITER -- requirements
Module: fire8_squeeze_ofm_writer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the bit width of one output-feature-map value.
REQ-002 The module SHALL have parameter DSP_NO, default 112, giving the number of channels delivered per sample.
REQ-003 The module SHALL have parameter WOUT, default 8, giving the output map side; pixels per layer PIX = WOUT**2.
REQ-004 The module SHALL have derived localparam ADDR_W = $clog2(DSP_NO*PIX), which is 13 at defaults.
REQ-005 clk  input  1  rising-edge clock, the single clock of the block.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 sample  input  1  one-cycle pulse meaning ofm holds a valid pixel vector; this is the squeeze layer's sample output.
REQ-008 ofm  input  [WIDTH-1:0] x DSP_NO (unpacked array)  per-channel results for the current pixel.
REQ-009 ram_we  output  1  write enable to the feature-map RAM.
REQ-010 ram_addr  output  ADDR_W  write address to the feature-map RAM.
REQ-011 ram_din  output  WIDTH  write data to the feature-map RAM.
REQ-012 ram_feedback  output  1  full map written; returned to the squeeze layer's ram_feedback input.
REQ-013 busy  output  1  high while a captured vector is being drained.
REQ-014 overrun_err  output  1  sticky flag: a sample was dropped.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, DRAIN and DONE.
REQ-016 In IDLE, a sample pulse SHALL capture all DSP_NO ofm words into an internal shadow buffer on that clock edge, clear channel counter ch to 0, and enter DRAIN.
REQ-017 In DRAIN, each cycle SHALL register ram_we=1, ram_addr=ch*PIX+pix and ram_din=buf[ch], then increment ch.
REQ-018 Memory layout SHALL be channel-major: channel c, pixel p at address c*PIX+p.
REQ-019 After the write with ch=DSP_NO-1, ch SHALL clear and pix SHALL increment; the FSM SHALL go to IDLE, or to DONE if pix was PIX-1.
REQ-020 Latency: sample high in cycle T gives ram_we high in cycles T+1..T+DSP_NO, with exactly DSP_NO writes per sample and no gaps.
REQ-021 ram_we SHALL be 0 in every cycle not listed in REQ-020.
REQ-022 A sample in the final DRAIN cycle (ch=DSP_NO-1) that does not complete the map SHALL be accepted: the buffer is recaptured, the cycle's write uses the old buffer value, and DRAIN continues with ch=0 and the next pix.
REQ-023 A sample in any other DRAIN cycle SHALL be ignored and SHALL set overrun_err; the buffer and counters SHALL be unchanged.
REQ-024 In DONE, ram_feedback SHALL be 1 and stay 1 until reset.
REQ-025 In DONE, samples SHALL be ignored and SHALL set overrun_err.
REQ-026 ram_feedback SHALL first rise in the cycle after the last write of pixel PIX-1.
REQ-027 busy SHALL equal (state==DRAIN).
REQ-028 All outputs SHALL be registered, with no combinational path from sample or ofm to any output.
REQ-029 Counter widths: ch SHALL be $clog2(DSP_NO) bits and pix SHALL be $clog2(PIX)+1 bits; neither SHALL wrap beyond its terminal value.

Reset
REQ-030 rst_n low SHALL asynchronously force: state=IDLE, ch=0, pix=0, ram_we=0, ram_addr=0, ram_din=0, ram_feedback=0, busy=0, overrun_err=0.
REQ-031 Shadow buffer contents SHALL NOT be reset.
REQ-032 Reset asserted mid-DRAIN SHALL abort without issuing further writes.
REQ-033 After reset release, the first sample SHALL restart writing at pixel 0.
REQ-034 Deassertion SHALL be applied on a clock edge with sample low.

Verification
REQ-035 Single pixel: ofm[c]=c+1, sample at T -> writes at T+1..T+112 with addr=c*64, din=c+1, ram_we low at T+113, busy high T+1..T+112.
REQ-036 Full layer: 64 samples spaced 3457 cycles apart with ofm[c]=p*256+c -> 7168 writes, each addr=c*64+p; ram_feedback rises after the last write and holds.
REQ-037 Back-to-back: second sample exactly in the ch=111 cycle -> accepted, 224 contiguous writes, overrun_err=0.
REQ-038 Overrun: second sample at ch=50 -> dropped, overrun_err=1 and stays 1, only 112 writes, pix=1.
REQ-039 Mid-drain reset: rst_n low at ch=30 -> ram_we=0 immediately; a new sample after release writes addr c*64+0.
REQ-040 Post-done: extra sample in DONE -> no write, ram_feedback stays 1, overrun_err=1.
